// File: rtl/alu_issue_if.sv
// Handshake and write-back bundle between the instruction source, the issue stage and the ALU.
// The stage itself takes the slave view; the upstream/ALU side takes the master view.
interface alu_issue_if;
    logic [31:0] Instr;
    logic        Instr_valid;
    logic        Instr_ready;
    logic [31:0] Src1;
    logic [31:0] Src2;
    logic [4:0]  Shamt;
    logic [5:0]  Funct;
    logic [4:0]  Rd_addr;
    logic        Out_valid;
    logic        Out_ready;
    logic        Wb_en;
    logic [4:0]  Wb_addr;
    logic [31:0] Wb_data;
    logic        Err;

    modport master (
        output Instr, Instr_valid, Out_ready, Wb_en, Wb_addr, Wb_data,
        input  Instr_ready, Src1, Src2, Shamt, Funct, Rd_addr, Out_valid, Err
    );

    modport slave (
        input  Instr, Instr_valid, Out_ready, Wb_en, Wb_addr, Wb_data,
        output Instr_ready, Src1, Src2, Shamt, Funct, Rd_addr, Out_valid, Err
    );
endinterface

// File: rtl/alu_issue_stage.sv
// Decode/operand-fetch stage: R-type decode, 32x32 register file with write-back bypass,
// pending-register scoreboard and a single registered output bundle towards the ALU.
module alu_issue_stage (
    input  logic       clk,
    input  logic       rst_n,
    alu_issue_if.slave bus
);
    localparam logic [5:0] FN_ADDU = 6'b001001;
    localparam logic [5:0] FN_SUBU = 6'b001010;
    localparam logic [5:0] FN_AND  = 6'b010001;
    localparam logic [5:0] FN_SLL  = 6'b100001;

    logic [31:0] regs_q [32];
    logic [31:0] regs_d [32];
    logic [31:0] pending_q, pending_d;
    logic        out_valid_q, out_valid_d;
    logic [31:0] src1_q, src1_d;
    logic [31:0] src2_q, src2_d;
    logic [4:0]  shamt_q, shamt_d;
    logic [5:0]  funct_q, funct_d;
    logic [4:0]  rd_addr_q, rd_addr_d;
    logic        err_q, err_d;

    logic [5:0]  opcode, funct;
    logic [4:0]  rs, rt, rd, shamt;
    logic        legal, is_sll, wb_write, stall, ready, accept;
    logic [31:0] rs_val, rt_val, busy_vec;

    assign opcode = bus.Instr[31:26];
    assign rs     = bus.Instr[25:21];
    assign rt     = bus.Instr[20:16];
    assign rd     = bus.Instr[15:11];
    assign shamt  = bus.Instr[10:6];
    assign funct  = bus.Instr[5:0];

    assign legal    = (opcode == 6'd0) &&
                      (funct == FN_ADDU || funct == FN_SUBU || funct == FN_AND || funct == FN_SLL);
    assign is_sll   = (funct == FN_SLL);
    assign wb_write = bus.Wb_en && (bus.Wb_addr != 5'd0);

    // Operand reads see a same-cycle write-back so a dependent op needs no extra bubble.
    always_comb begin
        rs_val = regs_q[rs];
        if (rs == 5'd0)
            rs_val = 32'd0;
        else if (bus.Wb_en && bus.Wb_addr == rs)
            rs_val = bus.Wb_data;
        rt_val = regs_q[rt];
        if (rt == 5'd0)
            rt_val = 32'd0;
        else if (bus.Wb_en && bus.Wb_addr == rt)
            rt_val = bus.Wb_data;
    end

    // A register whose result is arriving this cycle no longer counts as busy.
    always_comb begin
        busy_vec = pending_q;
        if (bus.Wb_en)
            busy_vec[bus.Wb_addr] = 1'b0;
    end

    assign stall  = bus.Instr_valid && legal &&
                    (busy_vec[rt] || (!is_sll && busy_vec[rs]) || busy_vec[rd]);
    assign ready  = rst_n && (!out_valid_q || bus.Out_ready) && !stall;
    assign accept = bus.Instr_valid && ready;

    always_comb begin
        regs_d      = regs_q;
        pending_d   = pending_q;
        out_valid_d = out_valid_q;
        src1_d      = src1_q;
        src2_d      = src2_q;
        shamt_d     = shamt_q;
        funct_d     = funct_q;
        rd_addr_d   = rd_addr_q;
        err_d       = accept && !legal;

        if (wb_write) begin
            regs_d[bus.Wb_addr]    = bus.Wb_data;
            pending_d[bus.Wb_addr] = 1'b0;
        end

        if (out_valid_q && bus.Out_ready)
            out_valid_d = 1'b0;

        if (accept && legal) begin
            out_valid_d = 1'b1;
            src1_d      = is_sll ? rt_val : rs_val;
            src2_d      = is_sll ? 32'd0 : rt_val;
            shamt_d     = shamt;
            funct_d     = funct;
            rd_addr_d   = rd;
            // Set is applied after clear so an issue and a write-back to the same rd keep it pending.
            if (rd != 5'd0)
                pending_d[rd] = 1'b1;
        end

        regs_d[0]    = 32'd0;
        pending_d[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 32; i++)
                regs_q[i] <= 32'd0;
            pending_q   <= 32'd0;
            out_valid_q <= 1'b0;
            src1_q      <= 32'd0;
            src2_q      <= 32'd0;
            shamt_q     <= 5'd0;
            funct_q     <= 6'd0;
            rd_addr_q   <= 5'd0;
            err_q       <= 1'b0;
        end else begin
            for (int i = 0; i < 32; i++)
                regs_q[i] <= regs_d[i];
            pending_q   <= pending_d;
            out_valid_q <= out_valid_d;
            src1_q      <= src1_d;
            src2_q      <= src2_d;
            shamt_q     <= shamt_d;
            funct_q     <= funct_d;
            rd_addr_q   <= rd_addr_d;
            err_q       <= err_d;
        end
    end

    assign bus.Instr_ready = ready;
    assign bus.Src1        = src1_q;
    assign bus.Src2        = src2_q;
    assign bus.Shamt       = shamt_q;
    assign bus.Funct       = funct_q;
    assign bus.Rd_addr     = rd_addr_q;
    assign bus.Out_valid   = out_valid_q;
    assign bus.Err         = err_q;
endmodule

// File: tb/tb_alu_issue_stage.sv
// Bench for alu_issue_stage: directed scenarios plus random traffic, all compared every cycle
// against a behavioural model of the register file, scoreboard and output bundle.
module tb_alu_issue_stage;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    alu_issue_if bus();

    alu_issue_stage dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    logic [31:0] in_instr;
    logic        in_valid, in_oready, in_wben;
    logic [4:0]  in_wbaddr;
    logic [31:0] in_wbdata;

    assign bus.Instr       = in_instr;
    assign bus.Instr_valid = in_valid;
    assign bus.Out_ready   = in_oready;
    assign bus.Wb_en       = in_wben;
    assign bus.Wb_addr     = in_wbaddr;
    assign bus.Wb_data     = in_wbdata;

    // Model state
    logic [31:0] m_regs [32];
    bit   [31:0] m_pend;
    logic        m_ov, m_err;
    logic [31:0] m_s1, m_s2;
    logic [4:0]  m_sh, m_rd;
    logic [5:0]  m_fn;

    int checks = 0;
    int failures = 0;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    function automatic logic [31:0] mk(logic [4:0] rs, logic [4:0] rt, logic [4:0] rd,
                                       logic [4:0] sh, logic [5:0] fn);
        return {6'd0, rs, rt, rd, sh, fn};
    endfunction

    function automatic bit is_legal(logic [31:0] i);
        return (i[31:26] == 6'd0) && (i[5:0] inside {6'h09, 6'h0a, 6'h11, 6'h21});
    endfunction

    function automatic logic [31:0] rd_val(logic [4:0] a);
        if (a == 5'd0) return 32'd0;
        if (in_wben && in_wbaddr == a) return in_wbdata;
        return m_regs[a];
    endfunction

    function automatic bit busy(logic [4:0] x);
        return m_pend[x] && !(in_wben && in_wbaddr == x);
    endfunction

    function automatic bit exp_ready();
        bit stall, sll;
        sll   = (in_instr[5:0] == 6'h21);
        stall = in_valid && is_legal(in_instr) &&
                (busy(in_instr[20:16]) || (!sll && busy(in_instr[25:21])) || busy(in_instr[15:11]));
        return (rst_n === 1'b1) && (!m_ov || in_oready) && !stall;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
        m_pend = '0;
        m_ov = 1'b0; m_err = 1'b0;
        m_s1 = '0; m_s2 = '0; m_sh = '0; m_rd = '0; m_fn = '0;
    endtask

    task automatic check_outputs();
        chk("out_valid", {31'd0, bus.Out_valid}, {31'd0, m_ov});
        chk("err",       {31'd0, bus.Err},       {31'd0, m_err});
        chk("src1",      bus.Src1,               m_s1);
        chk("src2",      bus.Src2,               m_s2);
        chk("shamt",     {27'd0, bus.Shamt},     {27'd0, m_sh});
        chk("funct",     {26'd0, bus.Funct},     {26'd0, m_fn});
        chk("rd_addr",   {27'd0, bus.Rd_addr},   {27'd0, m_rd});
    endtask

    // One clock cycle: inputs were set at the preceding falling edge.
    task automatic step();
        bit er, acc, leg, sll;
        logic [31:0] vs, vt;
        logic [4:0] rd;
        #1;
        er  = exp_ready();
        chk("instr_ready", {31'd0, bus.Instr_ready}, {31'd0, er});
        @(posedge clk);
        leg = is_legal(in_instr);
        sll = (in_instr[5:0] == 6'h21);
        rd  = in_instr[15:11];
        acc = in_valid && er;
        vs  = rd_val(in_instr[25:21]);
        vt  = rd_val(in_instr[20:16]);
        if (m_ov && in_oready) m_ov = 1'b0;
        if (acc && leg) begin
            m_ov = 1'b1;
            m_s1 = sll ? vt : vs;
            m_s2 = sll ? 32'd0 : vt;
            m_sh = in_instr[10:6];
            m_fn = in_instr[5:0];
            m_rd = rd;
        end
        m_err = acc && !leg;
        if (in_wben && in_wbaddr != 5'd0) begin
            m_regs[in_wbaddr] = in_wbdata;
            m_pend[in_wbaddr] = 1'b0;
        end
        if (acc && leg && rd != 5'd0) m_pend[rd] = 1'b1;
        if (acc)
            $display("t=%0t accept instr=%08h legal=%0d src1=%08h src2=%08h rd=%0d", $time,
                     in_instr, leg, m_s1, m_s2, rd);
        #1;
        check_outputs();
        @(negedge clk);
    endtask

    task automatic idle();
        in_valid = 1'b0; in_wben = 1'b0; in_oready = 1'b1;
        in_instr = 32'd0; in_wbaddr = 5'd0; in_wbdata = 32'd0;
    endtask

    task automatic wb(logic [4:0] a, logic [31:0] d);
        idle();
        in_wben = 1'b1; in_wbaddr = a; in_wbdata = d;
        step();
    endtask

    task automatic issue(logic [31:0] i);
        idle();
        in_valid = 1'b1; in_instr = i;
        step();
    endtask

    // Asserted between edges so the clear must be asynchronous to be seen.
    task automatic do_reset();
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        chk("rst_out_valid",   {31'd0, bus.Out_valid},   32'd0);
        chk("rst_instr_ready", {31'd0, bus.Instr_ready}, 32'd0);
        check_outputs();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        idle();
        rst_n = 1'b0;
        model_reset();
        @(negedge clk);
        do_reset();

        // Basic issue with operands from the register file
        wb(5'd5, 32'd7);
        wb(5'd6, 32'd3);
        issue(mk(5'd5, 5'd6, 5'd7, 5'd0, 6'h09));
        chk("pin_addu_src1", bus.Src1, 32'd7);
        chk("pin_addu_src2", bus.Src2, 32'd3);
        chk("pin_addu_funct", {26'd0, bus.Funct}, 32'h09);
        chk("pin_addu_rd", {27'd0, bus.Rd_addr}, 32'd7);

        // RAW hazard on x7, then release via same-cycle write-back
        idle(); in_valid = 1'b1; in_instr = mk(5'd7, 5'd6, 5'd8, 5'd0, 6'h0a);
        #1 chk("pin_stall_ready", {31'd0, bus.Instr_ready}, 32'd0);
        step();
        idle(); in_valid = 1'b1; in_instr = mk(5'd7, 5'd6, 5'd8, 5'd0, 6'h0a);
        in_wben = 1'b1; in_wbaddr = 5'd7; in_wbdata = 32'd10;
        step();
        chk("pin_bypass_src1", bus.Src1, 32'd10);
        chk("pin_bypass_src2", bus.Src2, 32'd3);

        // sll ignores a pending rs
        issue(mk(5'd0, 5'd0, 5'd7, 5'd0, 6'h09));
        issue(mk(5'd7, 5'd5, 5'd9, 5'd4, 6'h21));
        chk("pin_sll_src1", bus.Src1, 32'd7);
        chk("pin_sll_src2", bus.Src2, 32'd0);
        chk("pin_sll_shamt", {27'd0, bus.Shamt}, 32'd4);
        chk("pin_sll_funct", {26'd0, bus.Funct}, 32'h21);

        // Illegal instructions
        issue(mk(5'd1, 5'd2, 5'd3, 5'd0, 6'h20));
        chk("pin_illegal_err", {31'd0, bus.Err}, 32'd1);
        chk("pin_illegal_ov", {31'd0, bus.Out_valid}, 32'd0);
        issue({6'b000010, 26'h0000009});
        chk("pin_illegal2_err", {31'd0, bus.Err}, 32'd1);
        idle(); step();
        chk("pin_err_pulse", {31'd0, bus.Err}, 32'd0);
        wb(5'd0, 32'd55);
        issue(mk(5'd0, 5'd0, 5'd10, 5'd0, 6'h11));
        chk("pin_r0_zero", bus.Src1, 32'd0);

        // Drain scoreboard, then backpressure
        wb(5'd7, 32'd1); wb(5'd8, 32'd2); wb(5'd9, 32'd3); wb(5'd10, 32'd4);
        issue(mk(5'd5, 5'd6, 5'd11, 5'd0, 6'h09));
        for (int i = 0; i < 3; i++) begin
            idle(); in_oready = 1'b0; in_valid = 1'b1; in_instr = mk(5'd5, 5'd6, 5'd12, 5'd0, 6'h09);
            step();
        end
        chk("pin_bp_ov", {31'd0, bus.Out_valid}, 32'd1);
        chk("pin_bp_rd", {27'd0, bus.Rd_addr}, 32'd11);
        issue(mk(5'd5, 5'd6, 5'd12, 5'd0, 6'h09));
        chk("pin_bp_reload_ov", {31'd0, bus.Out_valid}, 32'd1);
        chk("pin_bp_reload_rd", {27'd0, bus.Rd_addr}, 32'd12);

        // Reset in the middle of traffic
        wb(5'd11, 32'd0); wb(5'd12, 32'd0);
        issue(mk(5'd0, 5'd0, 5'd7, 5'd0, 6'h09));
        idle(); in_oready = 1'b0; step();
        do_reset();
        issue(mk(5'd5, 5'd7, 5'd1, 5'd0, 6'h09));
        chk("pin_postrst_ov", {31'd0, bus.Out_valid}, 32'd1);
        chk("pin_postrst_src1", bus.Src1, 32'd0);
        chk("pin_postrst_src2", bus.Src2, 32'd0);

        // Random traffic over a small register window to provoke hazards
        for (int n = 0; n < 400; n++) begin
            logic [5:0] fn, op;
            case ($urandom_range(0, 9))
                0:       fn = 6'($urandom);
                1, 2:    fn = 6'h09;
                3, 4:    fn = 6'h0a;
                5, 6:    fn = 6'h11;
                default: fn = 6'h21;
            endcase
            op = ($urandom_range(0, 19) == 0) ? 6'($urandom) : 6'd0;
            in_instr  = {op, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                         5'($urandom_range(0, 7)), 5'($urandom), fn};
            in_valid  = ($urandom_range(0, 9) < 7);
            in_oready = ($urandom_range(0, 9) < 7);
            in_wben   = ($urandom_range(0, 9) < 4);
            in_wbaddr = 5'($urandom_range(0, 7));
            in_wbdata = $urandom;
            step();
            if (n == 200) do_reset();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/alu_issue_stage.md
# alu_issue_stage

Decode/operand-fetch stage sitting directly upstream of the ALU. It accepts 32-bit R-type instructions, decodes them, and reads operands from an internal 32x32 register file. It issues a registered operand bundle (Src1, Src2, Shamt, Funct, destination) to the ALU under a valid/ready handshake. ALU results return through a write-back port; a pending-register scoreboard stalls dependent instructions until their sources are written back.

## Interface
- No parameters; widths fixed (32-bit data, 5-bit register address).
- clk  input  1  single clock; all state updates on rising edge
- rst_n  input  1  reset, asynchronous, active-low
- Instr  input  32  instruction: [31:26] opcode, [25:21] rs, [20:16] rt, [15:11] rd, [10:6] shamt, [5:0] funct
- Instr_valid  input  1  Instr is present
- Instr_ready  output  1  stage accepts Instr this cycle (combinational)
- Src1  output  32  ALU operand 1 (registered)
- Src2  output  32  ALU operand 2 (registered)
- Shamt  output  5  shift amount (registered)
- Funct  output  6  ALU function code (registered)
- Rd_addr  output  5  destination register of issued op (registered)
- Out_valid  output  1  issued bundle valid
- Out_ready  input  1  ALU side consumes bundle
- Wb_en  input  1  write-back strobe
- Wb_addr  input  5  write-back register
- Wb_data  input  32  write-back data (ALU result)
- Err  output  1  one-cycle pulse: illegal instruction consumed

## Operation
- Legal instruction: opcode 000000 and funct in {001001 addu, 001010 subu, 010001 AND, 100001 sll}; anything else is illegal.
- Operand routing: addu/subu/AND → Src1=R[rs], Src2=R[rt]; sll → Src1=R[rt], Src2=0, rs ignored. Shamt=instr[10:6] for all ops, Funct=instr[5:0].
- Register file: R[0] reads 0 always; writes to address 0 ignored. Write-through read: when Wb_en and Wb_addr equals the read address (≠0), the read returns Wb_data.
- Scoreboard: 32-bit Pending mask, bit 0 always 0. Issuing an op with rd≠0 sets Pending[rd]. Wb_en with Wb_addr≠0 clears Pending[Wb_addr] and writes R[Wb_addr]. Set and clear of the same bit in one cycle: set wins.
- Source/destination busy: a used source or rd is busy if Pending[x]=1 and not (Wb_en and Wb_addr==x). Sources are rs,rt for addu/subu/AND and rt only for sll.
- Stall: Instr_valid, legal, and any used source or rd busy.
- Instr_ready = (~Out_valid | Out_ready) & ~stall. Illegal instructions are also gated by output space, so ordering is preserved.
- Accept = Instr_valid & Instr_ready.
  - Legal accept: load bundle, Out_valid←1.
  - Illegal accept: Out_valid←0 if the old bundle was consumed, else held; Err←1 next cycle; Pending unchanged.
- Out_valid & Out_ready & no accept → Out_valid←0. Bundle outputs hold their value whenever they are not reloaded.
- Wb_en is independent of the handshake and is applied every cycle it is asserted. Wb to a non-pending register still writes, and the mask is unchanged.

## Timing
- Reset (async assert, sync release): R[0..31]=0, Pending=0, Out_valid=0, Src1=Src2=0, Shamt=0, Funct=0, Rd_addr=0, Err=0. Instr_ready is 0 while rst_n=0.
- Latency: accept at edge N → bundle visible with Out_valid=1 after edge N.
- Throughput: one instruction per cycle when Out_ready=1 and there is no hazard.
- Dependent op: accepted in the same cycle its source's Wb_en arrives, using the bypassed Wb_data. Zero extra bubble beyond the ALU return.
- Write-back takes effect at the edge; the new value is readable in the same cycle via bypass.
- Reset mid-operation: the in-flight bundle, Pending mask and register contents are discarded immediately.

## Test plan
- Reset; Wb x5=7 and x6=3; issue addu rd=7 rs=5 rt=6 → next cycle Out_valid=1, Src1=7, Src2=3, Funct=001001, Rd_addr=7, Pending[7]=1.
- Issue subu rd=8 rs=7 rt=6 while x7 is pending → Instr_ready=0. Apply Wb x7=10 → accepted that cycle; bundle has Src1=10, Src2=3; Pending[7]=0, Pending[8]=1.
- sll rd=9 rt=5 shamt=4 with rs=7 pending → no stall; Src1=7, Src2=0, Shamt=4, Funct=100001.
- Illegal: funct 100000, then opcode 000010 → each consumed, Err pulses for 1 cycle, Out_valid stays 0, Pending unchanged. Wb x0=55 → R[0] still reads 0.
- Backpressure: Out_valid=1, Out_ready=0 for 3 cycles → bundle stable, Instr_ready=0. Raise Out_ready with a new valid instruction → consumed and reloaded in the same cycle, no bubble.
- Reset mid-stream: rst_n low with Out_valid=1 and Pending[7]=1 → Out_valid=0 immediately. After release, addu rs=5 rt=7 issues without stall, Src1=0, Src2=0.
